// File: rtl/vga_text_render_if.sv
// vga_text_render_if: text RAM and font ROM read bus between the renderer and its memories
interface vga_text_render_if;
  logic [11:0] tram_addr;
  logic [15:0] tram_data;
  logic [11:0] font_addr;
  logic [7:0]  font_data;
  modport master(output tram_addr, font_addr, input tram_data, font_data);
  modport slave(input tram_addr, font_addr, output tram_data, font_data);
endinterface

// File: rtl/vga_text_render.sv
// vga_text_render: 80x30 text-mode pixel pipeline with blinking underline cursor, 5-cycle latency
module vga_text_render #(
  parameter int COLS       = 80,
  parameter int BLINK_BITS = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [8:0]              row,
  input  logic [9:0]              col,
  input  logic                    active,
  input  logic                    hsync_in,
  input  logic                    vsync_in,
  input  logic [6:0]              cursor_x,
  input  logic [4:0]              cursor_y,
  input  logic                    cursor_en,
  vga_text_render_if.master       mem,
  output logic [11:0]             rgb,
  output logic                    hsync_out,
  output logic                    vsync_out
);
  logic [3:0]       act_d, hs_d, vs_d, cur_d;
  logic [3:0][2:0]  col_d;
  logic [1:0][3:0]  row_d;
  logic [7:0]       attr_d2, attr_d3;
  logic [BLINK_BITS-1:0] blink;
  logic             vs_q;
  logic             hit, pix;
  logic [11:0]      cell_addr;
  logic [3:0]       irgb;

  function automatic logic [11:0] expand(input logic [3:0] c);
    logic [3:0] hi, lo;
    hi = c[3] ? 4'hF : 4'hA;
    lo = c[3] ? 4'h5 : 4'h0;
    return {c[2] ? hi : lo, c[1] ? hi : lo, c[0] ? hi : lo};
  endfunction

  always_comb begin
    cell_addr = 12'(row[8:4]) * 12'(COLS) + 12'(col[9:3]);
    hit = active & cursor_en & blink[BLINK_BITS-1] & (row[8:4] == cursor_y) &
          (col[9:3] == cursor_x) & (row[3:1] == 3'b111);
    pix = mem.font_data[3'd7 - col_d[3]] | cur_d[3];
    irgb = pix ? attr_d3[3:0] : attr_d3[7:4];
  end

  // Attributes need a second stage so they line up with font_data at E4.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem.tram_addr <= '0;
      mem.font_addr <= '0;
      act_d         <= '0;
      hs_d          <= '0;
      vs_d          <= '0;
      cur_d         <= '0;
      col_d         <= '0;
      row_d         <= '0;
      attr_d2       <= '0;
      attr_d3       <= '0;
      rgb           <= '0;
      hsync_out     <= 1'b0;
      vsync_out     <= 1'b0;
      vs_q          <= 1'b0;
      blink         <= '0;
    end else begin
      mem.tram_addr <= active ? cell_addr : '0;
      act_d         <= {act_d[2:0], active};
      hs_d          <= {hs_d[2:0], hsync_in};
      vs_d          <= {vs_d[2:0], vsync_in};
      cur_d         <= {cur_d[2:0], hit};
      col_d         <= {col_d[2:0], col[2:0]};
      row_d         <= {row_d[0], row[3:0]};
      mem.font_addr <= {mem.tram_data[7:0], row_d[1]};
      attr_d2       <= mem.tram_data[15:8];
      attr_d3       <= attr_d2;
      rgb           <= act_d[3] ? expand(irgb) : '0;
      hsync_out     <= hs_d[3];
      vsync_out     <= vs_d[3];
      vs_q          <= vsync_in;
      if (vsync_in & ~vs_q) blink <= blink + 1'b1;
    end
  end
endmodule

// File: tb/tb_vga_text_render.sv
// tb_vga_text_render: directed checks of addressing, glyph colour, sync delay, reset and cursor blink
module tb_vga_text_render;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [8:0]  row = '0;
  logic [9:0]  col = '0;
  logic        active = 1'b0, hsync_in = 1'b1, vsync_in = 1'b0;
  logic [6:0]  cursor_x = '0;
  logic [4:0]  cursor_y = '0;
  logic        cursor_en = 1'b0;
  logic [11:0] rgb;
  logic        hsync_out, vsync_out;
  logic [15:0] ram_word = 16'h1F41;
  int          n_tests = 0, n_fail = 0;

  vga_text_render_if bus();

  vga_text_render dut (
    .clk(clk), .rst(rst), .row(row), .col(col), .active(active),
    .hsync_in(hsync_in), .vsync_in(vsync_in),
    .cursor_x(cursor_x), .cursor_y(cursor_y), .cursor_en(cursor_en),
    .mem(bus), .rgb(rgb), .hsync_out(hsync_out), .vsync_out(vsync_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    bus.tram_data <= ram_word;
    bus.font_data <= (bus.font_addr[11:4] == 8'h41) ? 8'h81 : 8'h00;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(2);
    rst = 1'b0;
  endtask

  task automatic probe(input string tag, input int r, input int c, input logic [31:0] exp);
    row = 9'(r);
    col = 10'(c);
    active = 1'b1;
    step(5);
    check(tag, 32'(rgb), exp);
    active = 1'b0;
  endtask

  task automatic vpulse(input int n);
    repeat (n) begin
      vsync_in = 1'b1;
      step(1);
      vsync_in = 1'b0;
      step(1);
    end
  endtask

  function automatic logic h_at(input int j);
    return !(j >= 5 && j < 101);
  endfunction

  function automatic logic v_at(input int j);
    return !(j >= 20 && j < 22);
  endfunction

  initial begin
    bus.tram_data = '0;
    bus.font_data = '0;
    step(2);
    rst = 1'b0;
    // reset asserted mid-line with live inputs
    active = 1'b1; row = 9'd37; col = 10'd100; hsync_in = 1'b1; vsync_in = 1'b1;
    step(6);
    #2 rst = 1'b1;
    #1;
    check("rst_rgb", 32'(rgb), 32'h0);
    check("rst_hsync", 32'(hsync_out), 32'h0);
    check("rst_vsync", 32'(vsync_out), 32'h0);
    check("rst_tram_addr", 32'(bus.tram_addr), 32'h0);
    check("rst_font_addr", 32'(bus.font_addr), 32'h0);
    step(1);
    rst = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      step(1);
      if (i < 5) begin
        check("post_rst_rgb", 32'(rgb), 32'h0);
        check("post_rst_hsync", 32'(hsync_out), 32'h0);
      end else begin
        check("post_rst_hsync_on", 32'(hsync_out), 32'h1);
        check("post_rst_rgb_bg", 32'(rgb), 32'h00A);
      end
    end
    // addressing
    row = 9'd37; col = 10'd100; active = 1'b1;
    step(1);
    check("addr_37_100", 32'(bus.tram_addr), 32'd172);
    step(2);
    check("font_addr_415", 32'(bus.font_addr), 32'h415);
    row = 9'd479; col = 10'd639;
    step(1);
    check("addr_479_639", 32'(bus.tram_addr), 32'd2399);
    active = 1'b0;
    step(1);
    check("addr_inactive", 32'(bus.tram_addr), 32'd0);
    // streamed glyph pixels across one cell, then blanking
    row = 9'd37;
    for (int k = 0; k < 13; k++) begin
      active = (k < 8);
      col = 10'(96 + k);
      step(1);
      if (k >= 4) begin
        int j;
        j = k - 4;
        check($sformatf("glyph_col%0d", j), 32'(rgb),
              j >= 8 ? 32'h0 : ((j == 0 || j == 7) ? 32'hFFF : 32'h00A));
      end
    end
    // sync windows with blanking
    active = 1'b0;
    for (int k = 0; k < 110; k++) begin
      hsync_in = h_at(k);
      vsync_in = v_at(k);
      step(1);
      check("hsync_delay", 32'(hsync_out), 32'(h_at(k - 4)));
      check("vsync_delay", 32'(vsync_out), 32'(v_at(k - 4)));
      check("blank_rgb", 32'(rgb), 32'h0);
    end
    // cursor blink
    vsync_in = 1'b0;
    hsync_in = 1'b1;
    ram_word = 16'h0F20;
    cursor_x = 7'd12; cursor_y = 5'd2; cursor_en = 1'b1;
    do_reset();
    probe("cur_frame0", 46, 100, 32'h0);
    vpulse(15);
    probe("cur_frame15", 46, 100, 32'h0);
    vpulse(1);
    probe("cur_on_r14", 46, 100, 32'hFFF);
    probe("cur_on_r15", 47, 103, 32'hFFF);
    probe("cur_on_r15_c96", 47, 96, 32'hFFF);
    probe("cur_on_r13", 45, 100, 32'h0);
    probe("cur_on_r0", 32, 100, 32'h0);
    probe("cur_next_cell", 46, 104, 32'h0);
    probe("cur_prev_cell", 46, 95, 32'h0);
    probe("cur_wrong_row", 30, 100, 32'h0);
    cursor_en = 1'b0;
    probe("cur_disabled_r14", 46, 100, 32'h0);
    probe("cur_disabled_r15", 47, 96, 32'h0);
    cursor_en = 1'b1;
    probe("cur_reenabled", 46, 100, 32'hFFF);
    vpulse(16);
    probe("cur_off_32", 46, 100, 32'h0);
    vpulse(16);
    cursor_x = 7'd100;
    probe("cur_out_of_range", 46, 100, 32'h0);
    probe("cur_out_of_range_c639", 47, 639, 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
